// File: rtl/fog_lut_streamer_pkg.sv
// Shared fog LUT definitions: table size and streamer state encodings.
// The interpolator imports LUT_WORDS_DEFAULT so both ends agree on table length.
package fog_lut_streamer_pkg;

  localparam int LUT_WORDS_DEFAULT = 66;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_FETCH = 2'd1;
  localparam logic [1:0] ST_SEND  = 2'd2;

endpackage

// File: rtl/fog_lut_ram.sv
// Simple dual-port LUT buffer: one write port, one read port with a registered,
// enable-gated read so the read register can double as a stall-holding output stage.
module fog_lut_ram
  import fog_lut_streamer_pkg::*;
#(
  parameter  int LUT_WORDS  = LUT_WORDS_DEFAULT,
  localparam int ADDR_WIDTH = $clog2(LUT_WORDS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [31:0]           wr_data,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [31:0]           rd_data
);

  logic [31:0] mem [LUT_WORDS];

  always_ff @(posedge clk) begin
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     rd_data <= '0;
    else if (rd_en) rd_data <= mem[rd_addr];
  end

endmodule

// File: rtl/fog_lut_streamer.sv
// Replays the buffered fog LUT as a 32-bit AXI-Stream on start, with tlast on
// the final word and full backpressure support.
module fog_lut_streamer
  import fog_lut_streamer_pkg::*;
#(
  parameter  int LUT_WORDS  = LUT_WORDS_DEFAULT,
  localparam int ADDR_WIDTH = $clog2(LUT_WORDS)
) (
  input  logic                  aclk,
  input  logic                  resetn,
  input  logic                  s_lut_wr_valid,
  output logic                  s_lut_wr_ready,
  input  logic [ADDR_WIDTH-1:0] s_lut_wr_addr,
  input  logic [31:0]           s_lut_wr_data,
  input  logic                  start,
  output logic                  busy,
  output logic                  done,
  output logic                  m_fog_lut_axis_tvalid,
  input  logic                  m_fog_lut_axis_tready,
  output logic                  m_fog_lut_axis_tlast,
  output logic [31:0]           m_fog_lut_axis_tdata
);

  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(LUT_WORDS - 1);

  logic [1:0]            state;
  logic [ADDR_WIDTH-1:0] rd_cnt;
  logic                  tvalid_q;
  logic                  tlast_q;
  logic                  done_q;
  logic                  hs;
  logic                  wr_en;
  logic                  rd_en;
  logic [ADDR_WIDTH-1:0] rd_addr;

  assign s_lut_wr_ready        = (state == ST_IDLE);
  assign busy                  = (state != ST_IDLE);
  assign done                  = done_q;
  assign m_fog_lut_axis_tvalid = tvalid_q;
  assign m_fog_lut_axis_tlast  = tlast_q;
  assign hs                    = tvalid_q && m_fog_lut_axis_tready;

  // Out-of-range addresses are still acknowledged, just not stored.
  assign wr_en = s_lut_wr_valid && s_lut_wr_ready && (s_lut_wr_addr <= LAST_IDX);

  // The RAM read register is the output register: reads fire only in FETCH and
  // on a non-final handshake, so a stalled beat keeps tdata stable.
  always_comb begin
    rd_en   = 1'b0;
    rd_addr = '0;
    if (state == ST_FETCH) begin
      rd_en = 1'b1;
    end else if (state == ST_SEND && hs && rd_cnt != LAST_IDX) begin
      rd_en   = 1'b1;
      rd_addr = rd_cnt + 1'b1;
    end
  end

  fog_lut_ram #(
    .LUT_WORDS(LUT_WORDS)
  ) u_ram (
    .clk     (aclk),
    .rst_n   (resetn),
    .wr_en   (wr_en),
    .wr_addr (s_lut_wr_addr),
    .wr_data (s_lut_wr_data),
    .rd_en   (rd_en),
    .rd_addr (rd_addr),
    .rd_data (m_fog_lut_axis_tdata)
  );

  always_ff @(posedge aclk or negedge resetn) begin
    if (!resetn) begin
      state    <= ST_IDLE;
      rd_cnt   <= '0;
      tvalid_q <= 1'b0;
      tlast_q  <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            state  <= ST_FETCH;
            rd_cnt <= '0;
          end
        end
        ST_FETCH: begin
          state    <= ST_SEND;
          tvalid_q <= 1'b1;
          tlast_q  <= 1'b0;
        end
        ST_SEND: begin
          if (hs) begin
            if (rd_cnt == LAST_IDX) begin
              state    <= ST_IDLE;
              tvalid_q <= 1'b0;
              tlast_q  <= 1'b0;
              done_q   <= 1'b1;
            end else begin
              rd_cnt  <= rd_cnt + 1'b1;
              tlast_q <= ((rd_cnt + 1'b1) == LAST_IDX);
            end
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fog_lut_streamer.sv
// Directed bench for fog_lut_streamer: load, stream, backpressure, ignored
// inputs, same-cycle write, mid-stream reset and back-to-back restart.
module tb_fog_lut_streamer;

  localparam int LW     = 66;
  localparam int ADDR_W = $clog2(LW);

  logic              aclk = 1'b0;
  logic              resetn;
  logic              wr_valid;
  logic              wr_ready;
  logic [ADDR_W-1:0] wr_addr;
  logic [31:0]       wr_data;
  logic              start;
  logic              busy;
  logic              done;
  logic              tvalid;
  logic              tready;
  logic              tlast;
  logic [31:0]       tdata;

  logic [31:0] exp_mem [LW];
  int checks = 0;
  int errors = 0;

  fog_lut_streamer #(
    .LUT_WORDS(LW)
  ) dut (
    .aclk                  (aclk),
    .resetn                (resetn),
    .s_lut_wr_valid        (wr_valid),
    .s_lut_wr_ready        (wr_ready),
    .s_lut_wr_addr         (wr_addr),
    .s_lut_wr_data         (wr_data),
    .start                 (start),
    .busy                  (busy),
    .done                  (done),
    .m_fog_lut_axis_tvalid (tvalid),
    .m_fog_lut_axis_tready (tready),
    .m_fog_lut_axis_tlast  (tlast),
    .m_fog_lut_axis_tdata  (tdata)
  );

  always #5 aclk = ~aclk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge aclk);
    #1;
  endtask

  task automatic write_word(input int a, input logic [31:0] d);
    wr_valid = 1'b1;
    wr_addr  = ADDR_W'(a);
    wr_data  = d;
    chk("wr_ready_idle", wr_ready, 1);
    tick();
    wr_valid = 1'b0;
    if (a < LW) exp_mem[a] = d;
  endtask

  // mode 0: tready held 1; mode 1: random tready.
  // inject 1: start + write at beat 10; inject 2: reset at beat 20.
  task automatic run_stream(input int mode, input int inject, input bit wr_at_start);
    int          beat;
    int          cyc;
    bit          stalled;
    bit          aborted;
    logic [31:0] pd;
    logic        pl;
    start = 1'b1;
    if (wr_at_start) begin
      wr_valid   = 1'b1;
      wr_addr    = ADDR_W'(3);
      wr_data    = 32'hDEAD_BEEF;
      exp_mem[3] = 32'hDEAD_BEEF;
    end
    tick();
    start    = 1'b0;
    wr_valid = 1'b0;
    chk("busy_t1", busy, 1);
    chk("tvalid_t1", tvalid, 0);
    chk("wr_ready_busy", wr_ready, 0);
    tick();
    beat = 0; cyc = 0; stalled = 0; aborted = 0; pd = '0; pl = 1'b0;
    while (beat < LW && cyc < 1000 && !aborted) begin
      if (inject == 2 && beat == 20) begin
        resetn = 1'b0;
        #1;
        chk("rst_tvalid", tvalid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_tlast", tlast, 0);
        chk("rst_done", done, 0);
        aborted = 1;
      end else begin
        tready = (mode == 0) ? 1'b1 : 1'($urandom_range(0, 1));
        if (inject == 1 && beat == 10) begin
          start    = 1'b1;
          wr_valid = 1'b1;
          wr_addr  = ADDR_W'(5);
          wr_data  = 32'h1234_5678;
          chk("wr_ready_send", wr_ready, 0);
        end
        chk("tvalid_held", tvalid, 1);
        if (stalled) begin
          chk("hold_tdata", tdata, pd);
          chk("hold_tlast", tlast, pl);
        end
        if (tready) begin
          chk("beat_tdata", tdata, exp_mem[beat]);
          chk("beat_tlast", tlast, (beat == LW - 1));
          beat++;
          stalled = 0;
        end else begin
          stalled = 1;
          pd = tdata;
          pl = tlast;
        end
        tick();
        cyc++;
        start    = 1'b0;
        wr_valid = 1'b0;
      end
    end
    tready = 1'b0;
    if (!aborted) begin
      chk("beat_count", beat, LW);
      if (mode == 0) chk("gapless_cycles", cyc, LW);
      chk("done_pulse", done, 1);
      chk("busy_fall", busy, 0);
      chk("tvalid_end", tvalid, 0);
    end
  endtask

  initial begin
    resetn   = 1'b0;
    wr_valid = 1'b0;
    wr_addr  = '0;
    wr_data  = '0;
    start    = 1'b0;
    tready   = 1'b0;
    repeat (3) tick();
    chk("reset_tvalid", tvalid, 0);
    chk("reset_tlast", tlast, 0);
    chk("reset_busy", busy, 0);
    chk("reset_done", done, 0);
    chk("reset_tdata", tdata, 0);
    resetn = 1'b1;
    tick();
    chk("ready_after_reset", wr_ready, 1);

    for (int i = 0; i < LW; i++) write_word(i, 32'hA000_0000 + 32'(i));

    run_stream(0, 0, 0);
    tick();
    run_stream(1, 0, 0);
    tick();
    run_stream(0, 1, 0);
    tick();
    chk("no_queued_start_busy", busy, 0);
    chk("no_queued_start_tvalid", tvalid, 0);
    run_stream(0, 0, 0);
    tick();

    write_word(70, 32'hFFFF_FFFF);
    run_stream(0, 0, 1);
    tick();

    run_stream(0, 2, 0);
    tick();
    tick();
    resetn = 1'b1;
    tick();
    chk("ready_after_midreset", wr_ready, 1);
    chk("tvalid_after_midreset", tvalid, 0);
    run_stream(0, 0, 0);
    run_stream(0, 0, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
